// File: rtl/disp_pattern_pkg.sv
// disp_pattern_pkg: mode codes, default LFSR taps and log2 helper
package disp_pattern_pkg;
  localparam logic [1:0] M_HOLD   = 2'd0;
  localparam logic [1:0] M_RAND   = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_COUNT  = 2'd3;
  localparam logic [31:0] DEF_TAPS = 32'h8020_0003;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/disp_pattern_gen_if.sv
// disp_pattern_gen_if: control inputs and pattern/tone outputs of the sequencer
interface disp_pattern_gen_if #(
  parameter int C_CH = 2,
  parameter int C_DW = 8,
  parameter int C_PW = 21,
  parameter int C_LW = 32
);
  logic                 EE_i;
  logic [C_PW-1:0]      PRESCALE_i;
  logic [2*C_CH-1:0]    MODEs_i;
  logic [C_CH*C_DW-1:0] LIMss_i;
  logic [15:0]          TONE_PER_i;
  logic [C_CH*C_DW-1:0] DATss_o;
  logic [C_LW-1:0]      LFSR_o;
  logic                 STEP_EE_o;
  logic                 SOUND_o;
  modport master (
    output EE_i, PRESCALE_i, MODEs_i, LIMss_i, TONE_PER_i,
    input  DATss_o, LFSR_o, STEP_EE_o, SOUND_o
  );
  modport slave (
    input  EE_i, PRESCALE_i, MODEs_i, LIMss_i, TONE_PER_i,
    output DATss_o, LFSR_o, STEP_EE_o, SOUND_o
  );
endinterface

// File: rtl/disp_pattern_chan.sv
// disp_pattern_chan: one pattern channel (data/direction registers and mode mux)
module disp_pattern_chan
  import disp_pattern_pkg::*;
#(
  parameter int C_DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic [1:0]      mode,
  input  logic [C_DW-1:0] lim,
  input  logic [C_DW-1:0] rnd,
  output logic [C_DW-1:0] d
);
  logic            up, up_nx, b_up;
  logic [C_DW-1:0] d_nx, b_nx;
  always_comb begin
    b_nx  = lim == '0 ? '0 : up ? (d < lim ? d + 1'b1 : d - 1'b1) : (d == '0 ? C_DW'(1) : d - 1'b1);
    b_up  = lim == '0 || (up ? d < lim : d == '0);
    d_nx  = mode == M_RAND ? rnd : mode == M_BOUNCE ? b_nx : mode == M_COUNT ? d + 1'b1 : d;
    up_nx = mode == M_BOUNCE ? b_up : up;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d  <= '0;
      up <= 1'b1;
    end else if (step) begin
      d  <= d_nx;
      up <= up_nx;
    end
  end
endmodule

// File: rtl/disp_pattern_gen.sv
// disp_pattern_gen: prescaled pattern sequencer with shared LFSR and tone output
module disp_pattern_gen
  import disp_pattern_pkg::*;
#(
  parameter int C_CH = 2,
  parameter int C_DW = 8,
  parameter int C_PW = 21,
  parameter int C_LW = 32,
  parameter logic [C_LW-1:0] C_TAPS = C_LW'(DEF_TAPS)
) (
  input logic CK_i,
  input logic RST_i,
  disp_pattern_gen_if.slave bus
);
  logic [C_PW-1:0]      pctr;
  logic [C_LW-1:0]      lfsr, lfsr_nx;
  logic [15:0]          tctr;
  logic                 sound, step_ee, step;
  logic [C_CH*C_DW-1:0] dat;
  assign step    = bus.EE_i && pctr == '0;
  assign lfsr_nx = {lfsr[C_LW-2:0], ^(C_TAPS & lfsr)};
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      pctr    <= '0;
      lfsr    <= '1;
      step_ee <= 1'b0;
    end else begin
      pctr    <= step ? bus.PRESCALE_i : bus.EE_i ? pctr - 1'b1 : pctr;
      lfsr    <= step ? lfsr_nx : lfsr;
      step_ee <= step;
    end
  end
  // >= rather than == so lowering the half-period below the count toggles at once
  always_ff @(posedge CK_i) begin
    if (RST_i || bus.TONE_PER_i == '0) begin
      tctr  <= '0;
      sound <= 1'b0;
    end else if (bus.EE_i) begin
      tctr  <= tctr >= bus.TONE_PER_i - 16'd1 ? '0 : tctr + 16'd1;
      sound <= tctr >= bus.TONE_PER_i - 16'd1 ? ~sound : sound;
    end
  end
  for (genvar k = 0; k < C_CH; k++) begin : g_ch
    localparam int R = k % C_DW;
    logic [2*C_DW-1:0] dd;
    assign dd = {lfsr_nx[C_DW-1:0], lfsr_nx[C_DW-1:0]} << R;
    disp_pattern_chan #(.C_DW(C_DW)) u_chan (
      .clk  (CK_i),
      .rst  (RST_i),
      .step (step),
      .mode (bus.MODEs_i[2*k +: 2]),
      .lim  (bus.LIMss_i[k*C_DW +: C_DW]),
      .rnd  (dd[2*C_DW-1:C_DW]),
      .d    (dat[k*C_DW +: C_DW])
    );
  end
  assign bus.DATss_o   = dat;
  assign bus.LFSR_o    = lfsr;
  assign bus.STEP_EE_o = step_ee;
  assign bus.SOUND_o   = sound;
endmodule

// File: tb/tb_disp_pattern_gen.sv
// tb_disp_pattern_gen: directed and randomized checks against a behavioural model
module tb_disp_pattern_gen;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ee = 1'b0;
  logic [20:0] pre = '0;
  logic [5:0]  modes = '0;
  logic [23:0] lims = '0;
  logic [15:0] tper = '0;
  int          checks = 0;
  int          errors = 0;
  int          m_pctr, m_tctr;
  logic [31:0] m_l;
  int          m_d[3];
  bit          m_u[3];
  bit          m_snd, m_stp;

  always #5 clk = ~clk;

  disp_pattern_gen_if #(.C_CH(3), .C_DW(8), .C_PW(21), .C_LW(32)) bus ();
  assign bus.EE_i       = ee;
  assign bus.PRESCALE_i = pre;
  assign bus.MODEs_i    = modes;
  assign bus.LIMss_i    = lims;
  assign bus.TONE_PER_i = tper;

  disp_pattern_gen #(.C_CH(3), .C_DW(8), .C_PW(21), .C_LW(32), .C_TAPS(TAPS)) dut (
    .CK_i  (clk),
    .RST_i (rst),
    .bus   (bus)
  );

  function automatic int rotl(input int v, input int r);
    return ((v << r) | (v >> (8 - r))) & 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int dat(input int k);
    return int'(bus.DATss_o[8*k +: 8]);
  endfunction

  // One clock: advance the model with the inputs sampled at this edge, then compare.
  task automatic cyc();
    bit s;
    int lim;
    @(posedge clk);
    if (rst) begin
      m_pctr = 0; m_l = '1; m_stp = 0; m_tctr = 0; m_snd = 0;
      for (int k = 0; k < 3; k++) begin m_d[k] = 0; m_u[k] = 1; end
    end else begin
      s = ee && m_pctr == 0;
      m_stp = s;
      if (s) m_pctr = int'(pre);
      else if (ee) m_pctr--;
      if (s) begin
        m_l = {m_l[30:0], ^(m_l & TAPS)};
        for (int k = 0; k < 3; k++) begin
          lim = int'(lims[8*k +: 8]);
          case (modes[2*k +: 2])
            2'd1: m_d[k] = rotl(int'(m_l[7:0]), k % 8);
            2'd2: begin
              if (lim == 0) begin m_d[k] = 0; m_u[k] = 1; end
              else if (m_u[k] && m_d[k] < lim) m_d[k]++;
              else if (m_u[k]) begin m_d[k]--; m_u[k] = 0; end
              else if (m_d[k] == 0) begin m_d[k] = 1; m_u[k] = 1; end
              else m_d[k]--;
            end
            2'd3: m_d[k] = (m_d[k] + 1) % 256;
            default: ;
          endcase
        end
      end
      if (tper == 0) begin m_tctr = 0; m_snd = 0; end
      else if (ee) begin
        if (m_tctr >= int'(tper) - 1) begin m_tctr = 0; m_snd = ~m_snd; end
        else m_tctr++;
      end
    end
    #1;
    chk("step", 32'(bus.STEP_EE_o), 32'(m_stp));
    chk("lfsr", bus.LFSR_o, m_l);
    for (int k = 0; k < 3; k++) chk($sformatf("dat%0d", k), 32'(dat(k)), 32'(m_d[k]));
    chk("sound", 32'(bus.SOUND_o), 32'(m_snd));
  endtask

  task automatic do_reset();
    rst = 1; ee = 0;
    cyc();
    rst = 0;
  endtask

  initial begin
    int t0, t1, exp_d;
    bit prev;
    cyc(); cyc();
    chk("rst_lfsr", bus.LFSR_o, 32'hFFFF_FFFF);
    chk("rst_dat", 32'(bus.DATss_o), 32'h0);
    // prescaler: step on tick 1, then every 4 ticks
    rst = 0; pre = 3; ee = 1;
    cyc();
    chk("a_step1", 32'(bus.STEP_EE_o), 32'h1);
    chk("a_lfsr1", bus.LFSR_o, 32'hFFFF_FFFE);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("a_period", 32'(bus.STEP_EE_o), 32'((i % 4) == 0));
    end
    // bounce with limit 7, then limit lowered to 3 while at 6
    do_reset();
    pre = 0; modes = 6'b000010; lims = 24'd7; ee = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      exp_d = i <= 6 ? i + 1 : i <= 13 ? 13 - i : i - 13;
      chk("b_bounce", 32'(dat(0)), 32'(exp_d));
    end
    lims[7:0] = 8'd3;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("b_lower", 32'(dat(0)), 32'(5 - i));
    end
    // wrap counter over 256 steps, neighbour on hold
    do_reset();
    pre = 0; modes = 6'b001100; lims = '0; ee = 1;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (i == 254) chk("c_255", 32'(dat(1)), 32'd255);
    end
    chk("c_wrap", 32'(dat(1)), 32'd0);
    chk("c_hold", 32'(dat(0)), 32'd0);
    // tone: half-period 5 ticks, tick every other cycle
    do_reset();
    modes = '0; tper = 5; t0 = -1; t1 = -1; prev = 0;
    for (int c = 0; c < 100; c++) begin
      ee = (c % 2) == 0;
      cyc();
      if (!prev && bus.SOUND_o === 1'b1) begin
        if (t0 < 0) t0 = c;
        else if (t1 < 0) t1 = c;
      end
      prev = bus.SOUND_o;
    end
    chk("d_period", 32'(t1 - t0), 32'd20);
    for (int c = 0; c < 30 && bus.SOUND_o !== 1'b1; c++) begin
      ee = ~ee;
      cyc();
    end
    chk("d_high", 32'(bus.SOUND_o), 32'h1);
    tper = 0;
    cyc();
    chk("d_mute", 32'(bus.SOUND_o), 32'h0);
    // reset coinciding with a step
    do_reset();
    pre = 0; modes = 6'b111111; ee = 1;
    cyc(); cyc();
    rst = 1;
    cyc();
    chk("e_nostep", 32'(bus.STEP_EE_o), 32'h0);
    chk("e_lfsr", bus.LFSR_o, 32'hFFFF_FFFF);
    chk("e_dat", 32'(bus.DATss_o), 32'h0);
    rst = 0;
    cyc();
    chk("e_step", 32'(bus.STEP_EE_o), 32'h1);
    chk("e_lfsr1", bus.LFSR_o, 32'hFFFF_FFFE);
    // all channels random, arbitrary limits
    modes = 6'b010101;
    for (int i = 0; i < 10; i++) begin
      lims = 24'($urandom);
      cyc();
      for (int k = 0; k < 3; k++) chk("f_rot", 32'(dat(k)), 32'(rotl(int'(m_l[7:0]), k)));
    end
    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      ee = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 19) == 0) begin
        pre = 21'($urandom_range(0, 5));
        modes = 6'($urandom);
        lims = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
        tper = 16'($urandom_range(0, 6));
      end
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_pattern_gen.md
# disp_pattern_gen

Parametrised test-pattern and tone sequencer for the NTSC square-display FPGA layer. It drives the display data words and the sounder pin from a shared prescaler, a shared Fibonacci LFSR, and C_CH independent pattern channels. Each channel's mode is selectable at run time: hold, pseudo-random, bounce (triangle) or wrap counter. It sits beside the NTSC video core, is clocked by the core clock, and advances on the core's pixel-clock enable.

## Interface
- C_CH, 2: number of pattern channels (1..8)
- C_DW, 8: data width per channel (2..16)
- C_PW, 21: prescaler width
- C_LW, 32: LFSR width (≥ C_DW)
- C_TAPS, 32'h8020_0003: LFSR tap mask, width C_LW
- CK_i  in  1  sole clock; all state on rising edge
- RST_i  in  1  reset: one clock, synchronous, active-high
- EE_i  in  1  tick enable (pixel-clock enable from the video core)
- PRESCALE_i  in  C_PW  prescaler reload; step period = PRESCALE_i+1 ticks
- MODEs_i  in  2*C_CH  per-channel mode, channel k at [2k+1:2k]
- LIMss_i  in  C_CH*C_DW  per-channel bounce upper limit
- TONE_PER_i  in  16  tone half-period in ticks; 0 = mute
- DATss_o  out  C_CH*C_DW  channel data, channel k at [(k+1)*C_DW-1:k*C_DW]
- LFSR_o  out  C_LW  current LFSR state
- STEP_EE_o  out  1  one-cycle pulse, registered, marks a step
- SOUND_o  out  1  square-wave tone

## Operation
- Step condition S = EE_i && PCTR==0.
  - On S: PCTR ← PRESCALE_i.
  - Else on EE_i: PCTR ← PCTR−1.
  - With PRESCALE_i=0, S fires on every tick.
- LFSR: on S, L ← {L[C_LW-2:0], ^(C_TAPS & L)}. It advances on every step, regardless of channel modes.
- Per channel k on S, with D = data and U = direction (1 = up):
  - Mode 0, hold: D unchanged.
  - Mode 1, random: D ← next-L[C_DW-1:0], rotated left by (k mod C_DW).
  - Mode 2, bounce, when LIM == 0: D ← 0 and U ← 1.
  - Mode 2, bounce, when U=1 and D<LIM: D ← D+1.
  - Mode 2, bounce, when U=1 and D≥LIM: D ← D−1 and U ← 0.
  - Mode 2, bounce, when U=0 and D==0: D ← 1 and U ← 1.
  - Mode 2, bounce, when U=0 and D>0: D ← D−1.
  - Mode 3, counter: D ← D+1, wrapping modulo 2^C_DW.
  - U changes only in mode 2. A mode change takes effect at the next step and keeps D.
  - If LIM is lowered below D, the channel descends on the next steps. This is covered by the D≥LIM rule.
- Tone:
  - If TONE_PER_i==0: TCTR ← 0 and SOUND_o ← 0, every cycle.
  - Else on EE_i: if TCTR ≥ TONE_PER_i−1, then TCTR ← 0 and SOUND_o toggles; otherwise TCTR ← TCTR+1.
  - Tone timing is independent of the prescaler.
- Widths: all arithmetic is unsigned at C_DW, C_PW and 16 bits. No carries out.

## Timing
- All outputs are registered. Updates appear in the cycle after the CK_i edge that sampled EE_i=1.
- STEP_EE_o is high for exactly the cycle in which the new DATss_o and LFSR_o are first visible.
- Reset values:
  - DATss_o=0, U=1 for every channel.
  - LFSR_o all ones.
  - PCTR=0, so the first EE_i after reset is a step.
  - TCTR=0, SOUND_o=0, STEP_EE_o=0.
- RST_i overrides EE_i in the same cycle. Reset mid-step discards that step.
- PRESCALE_i is sampled only at reload. Changing it mid-count does not shorten the current period.
- TONE_PER_i is sampled every tick. Lowering it below TCTR toggles on the next tick.

## Structure
- Package disp_pattern_pkg holds:
  - mode constants M_HOLD=0, M_RAND=1, M_BOUNCE=2, M_COUNT=3;
  - the default tap mask;
  - the log2 function.
- Sub-module disp_pattern_chan contains one channel's D/U registers and mode mux. Its inputs are step, mode, lim and the rotated LFSR word. It is instantiated C_CH times in a generate loop.
- The prescaler, LFSR and tone counter stay in the top level.

## Test plan
- Reset, then PRESCALE_i=3 with EE_i held high:
  - STEP_EE_o pulses on tick 1, then every 4 ticks.
  - LFSR_o goes FFFF_FFFF → FFFF_FFFE on the first step. The feedback of all ones with 4 taps is 0.
- Channel 0 in mode 2 with LIM=7, PRESCALE_i=0:
  - D sequence 1,2,…,7,6,…,0,1.
  - Then change LIM to 3 while D=6: D descends 5,4,3,2.
- Mode 3 with C_DW=8, starting from reset: after 256 steps D=0. Mode 0 in another channel stays 0 throughout.
- TONE_PER_i=5, EE_i every 2nd cycle:
  - SOUND_o period is 20 cycles.
  - Set TONE_PER_i=0: SOUND_o is 0 on the next cycle.
- Assert RST_i in the same cycle as a step with EE_i=1:
  - All outputs take their reset values.
  - No STEP_EE_o pulse.
  - The next EE_i steps.
- C_CH=3, all channels in mode 1:
  - Channel k equals LFSR_o[7:0] rotated left by k after each step.
  - No channel is ever affected by another channel's LIM.
